// File: rtl/com_color_scheduler_pkg.sv
// Shared types and constants for the centre-of-mass colour scheduler.
package com_pkg;

   // Colour codes as seen by centerOfMass on colorSelect (3 is never driven)
   localparam logic [1:0] COLOR_RED   = 2'd0;
   localparam logic [1:0] COLOR_GREEN = 2'd1;
   localparam logic [1:0] COLOR_BLUE  = 2'd2;

   // Width of one centre coordinate coming out of the divider
   localparam int COM_W = 10;

   // Frame sequencer states
   typedef enum logic [1:0] {
      S_SYNC    = 2'd0,
      S_ACCUM   = 2'd1,
      S_DIVWAIT = 2'd2
   } com_state_e;

endpackage

// File: rtl/com_color_scheduler_if.sv
// Per-colour result bus from the scheduler to downstream consumers.
//
// Handshake: resultStrobe is a one-cycle valid pulse with no ready/backpressure;
// in the strobe cycle resultColor names the bank slot that was just written, and
// centerX/centerY/centerValid already show the new contents. Consumers that miss
// the pulse can still read the bank at any time; centerValid tells them whether
// a slot is fresh.
interface com_color_scheduler_if;
   import com_pkg::*;

   logic [3*COM_W-1:0] centerX;      // {blue, green, red}
   logic [3*COM_W-1:0] centerY;      // {blue, green, red}
   logic [2:0]         centerValid;
   logic               resultStrobe;
   logic [1:0]         resultColor;

   modport master (
      output centerX, centerY, centerValid, resultStrobe, resultColor
   );

   modport slave (
      input centerX, centerY, centerValid, resultStrobe, resultColor
   );

endinterface

// File: rtl/com_color_scheduler_next_color.sv
// Combinational colour picker: next enabled colour after the current one in
// red->green->blue->red order, and the lowest enabled colour.
module com_next_color
   import com_pkg::*;
(
   input  logic [1:0] i_color,
   input  logic [2:0] i_mask,
   output logic [1:0] o_next,
   output logic [1:0] o_lowest
);

   // Lowest enabled colour; with an empty mask the current colour is kept
   always_comb begin
      o_lowest = i_color;
      if (i_mask[0])      o_lowest = COLOR_RED;
      else if (i_mask[1]) o_lowest = COLOR_GREEN;
      else if (i_mask[2]) o_lowest = COLOR_BLUE;
   end

   // Search forward with wrap; a lone enabled colour maps to itself
   always_comb begin
      o_next = i_color;
      case (i_color)
         COLOR_RED:   o_next = i_mask[1] ? COLOR_GREEN : (i_mask[2] ? COLOR_BLUE  : COLOR_RED);
         COLOR_GREEN: o_next = i_mask[2] ? COLOR_BLUE  : (i_mask[0] ? COLOR_RED   : COLOR_GREEN);
         default:     o_next = i_mask[0] ? COLOR_RED   : (i_mask[1] ? COLOR_GREEN : COLOR_BLUE);
      endcase
   end

endmodule

// File: rtl/com_color_scheduler.sv
// Frame-level sequencer for centerOfMass: rotates colorSelect over the enabled
// colours, waits out the divider after each frame, and banks per-colour centres
// with valid/stale tracking.
module com_color_scheduler
   import com_pkg::*;
#(
   parameter int DIV_LATENCY      = 32,
   parameter int FRAMES_PER_COLOR = 1,
   parameter int STALE_FRAMES     = 8
) (
   input  logic                  clk,
   input  logic                  reset,        // asynchronous, active-low
   input  logic [10:0]           x,
   input  logic [9:0]            y,
   input  logic [2:0]            colorEnable,
   input  logic [COM_W-1:0]      xCenter,
   input  logic [COM_W-1:0]      yCenter,
   output logic [1:0]            colorSelect,
   output logic                  overrun,
   output com_state_e            dbg_state,
   com_color_scheduler_if.master res
);

   localparam int LAT_W   = $clog2(DIV_LATENCY + 1);
   localparam int DWELL_W = (FRAMES_PER_COLOR > 1) ? $clog2(FRAMES_PER_COLOR + 1) : 1;
   localparam int STALE_W = $clog2(STALE_FRAMES + 1);

   localparam logic [LAT_W-1:0]   LAT_INIT   = LAT_W'(DIV_LATENCY - 1);
   localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(FRAMES_PER_COLOR - 1);
   localparam logic [DWELL_W-1:0] DWELL_MAX  = '1;
   localparam logic [STALE_W-1:0] STALE_LAST = STALE_W'(STALE_FRAMES - 1);
   localparam logic [STALE_W-1:0] STALE_MAX  = '1;

   com_state_e         r_state;
   com_state_e         w_state_next;
   logic               r_origin_d;
   logic               w_fs;
   logic [1:0]         r_color;
   logic [1:0]         w_color_next;
   logic [DWELL_W-1:0] r_dwell;
   logic [DWELL_W-1:0] w_dwell_next;
   logic [1:0]         w_next;
   logic [1:0]         w_lowest;
   logic [LAT_W-1:0]   r_lat;
   logic [1:0]         r_pend;
   logic               w_capture;
   logic               w_load_pend;
   logic               w_overrun_set;
   logic               r_overrun;
   logic               r_strobe;
   logic [1:0]         r_rcolor;
   logic [COM_W-1:0]   r_cx [3];
   logic [COM_W-1:0]   r_cy [3];
   logic [2:0]         r_valid;
   logic [STALE_W-1:0] r_stale [3];

   // Frame start is the rising edge of "pixel is at the origin"
   assign w_fs = (x == 11'd0) && (y == 10'd0) && !r_origin_d;

   com_next_color u_next_color (
      .i_color  (r_color),
      .i_mask   (colorEnable),
      .o_next   (w_next),
      .o_lowest (w_lowest)
   );

   // Colour rule, evaluated only on frame start against the enable mask seen then
   always_comb begin
      w_color_next = r_color;
      w_dwell_next = r_dwell;
      if (w_fs && (colorEnable != 3'b000)) begin
         if (!colorEnable[r_color]) begin
            w_color_next = w_lowest;
            w_dwell_next = '0;
         end else if (r_dwell == DWELL_LAST) begin
            w_color_next = w_next;
            w_dwell_next = '0;
         end else if (r_dwell != DWELL_MAX) begin
            w_dwell_next = r_dwell + DWELL_W'(1);
         end
      end
   end

   // Next state: the first frame is discarded, then each frame arms a capture
   always_comb begin
      w_state_next  = r_state;
      w_capture     = 1'b0;
      w_load_pend   = 1'b0;
      w_overrun_set = 1'b0;
      case (r_state)
         S_SYNC: begin
            if (w_fs) w_state_next = S_ACCUM;
         end
         S_ACCUM: begin
            if (w_fs) begin
               w_load_pend  = 1'b1;
               w_state_next = S_DIVWAIT;
            end
         end
         S_DIVWAIT: begin
            if (w_fs) begin
               // A new frame before the divider settled: drop the old capture
               w_load_pend   = 1'b1;
               w_overrun_set = 1'b1;
            end else if (r_lat == '0) begin
               w_capture    = 1'b1;
               w_state_next = S_ACCUM;
            end
         end
         default: w_state_next = S_SYNC;
      endcase
   end

   // State, colour selection, frame-start edge detect and divider wait counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= S_SYNC;
         r_origin_d <= 1'b0;
         r_color    <= COLOR_RED;
         r_dwell    <= '0;
         r_lat      <= '0;
         r_pend     <= COLOR_RED;
      end else begin
         r_state    <= w_state_next;
         r_origin_d <= (x == 11'd0) && (y == 10'd0);
         r_color    <= w_color_next;
         r_dwell    <= w_dwell_next;
         if (w_load_pend) begin
            r_pend <= r_color;
            r_lat  <= LAT_INIT;
         end else if ((r_state == S_DIVWAIT) && (r_lat != '0)) begin
            r_lat  <= r_lat - LAT_W'(1);
         end
      end
   end

   // Result bank with per-colour staleness; a capture beats a stale clear
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_valid <= 3'b000;
         for (int c = 0; c < 3; c++) begin
            r_cx[c]    <= '0;
            r_cy[c]    <= '0;
            r_stale[c] <= '0;
         end
      end else begin
         for (int c = 0; c < 3; c++) begin
            if (w_capture && (r_pend == 2'(c))) begin
               r_cx[c]    <= xCenter;
               r_cy[c]    <= yCenter;
               r_valid[c] <= 1'b1;
               r_stale[c] <= '0;
            end else if (w_fs && r_valid[c]) begin
               if (r_stale[c] != STALE_MAX) r_stale[c] <= r_stale[c] + STALE_W'(1);
               if (r_stale[c] >= STALE_LAST) r_valid[c] <= 1'b0;
            end
         end
      end
   end

   // Capture strobe one cycle after the write decision, and sticky overrun
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_strobe  <= 1'b0;
         r_rcolor  <= COLOR_RED;
         r_overrun <= 1'b0;
      end else begin
         r_strobe <= w_capture;
         if (w_capture)     r_rcolor  <= r_pend;
         if (w_overrun_set) r_overrun <= 1'b1;
      end
   end

   assign colorSelect      = r_color;
   assign overrun          = r_overrun;
   assign dbg_state        = r_state;
   assign res.centerX      = {r_cx[2], r_cx[1], r_cx[0]};
   assign res.centerY      = {r_cy[2], r_cy[1], r_cy[0]};
   assign res.centerValid  = r_valid;
   assign res.resultStrobe = r_strobe;
   assign res.resultColor  = r_rcolor;

endmodule

// File: tb/tb_com_color_scheduler.sv
// Directed bench for com_color_scheduler: a short-latency instance exercises
// rotation, capture, staleness and reset; a long-latency instance driven by the
// same pixels must only ever report overrun.
module tb_com_color_scheduler;
   import com_pkg::*;

   // Clock and reset
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   logic [10:0] x;
   logic [9:0]  y;
   logic [2:0]  en;
   logic [9:0]  xc, yc;
   logic [1:0]  cs1, cs2;
   logic        ov1, ov2;
   com_state_e  st1, st2;

   com_color_scheduler_if if1();
   com_color_scheduler_if if2();

   com_color_scheduler #(.DIV_LATENCY(4), .FRAMES_PER_COLOR(1), .STALE_FRAMES(2)) dut (
      .clk(clk), .reset(rst_n), .x(x), .y(y), .colorEnable(en),
      .xCenter(xc), .yCenter(yc), .colorSelect(cs1), .overrun(ov1),
      .dbg_state(st1), .res(if1)
   );

   com_color_scheduler #(.DIV_LATENCY(40), .FRAMES_PER_COLOR(1), .STALE_FRAMES(8)) dut_slow (
      .clk(clk), .reset(rst_n), .x(x), .y(y), .colorEnable(en),
      .xCenter(xc), .yCenter(yc), .colorSelect(cs2), .overrun(ov2),
      .dbg_state(st2), .res(if2)
   );

   int n_vec  = 0;
   int n_fail = 0;

   // Scoreboard check
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Per-frame observations
   logic [1:0] f_c0, f_cend, f_scol;
   logic [2:0] f_v0;
   int         f_ns, f_sk, f_ns2;

   // Driver: one 4x4 frame, fs at pixel 0; optional enable change at pixel 8
   task automatic run_frame(input logic [9:0] fxc, input logic [9:0] fyc, input logic [2:0] en_mid);
      xc = fxc; yc = fyc;
      f_ns = 0; f_sk = -1; f_ns2 = 0; f_scol = 2'd0;
      for (int k = 0; k < 16; k++) begin
         x = 11'(k % 4);
         y = 10'(k / 4);
         if (k == 8) en = en_mid;
         @(posedge clk); #1;
         if (k == 0) begin f_c0 = cs1; f_v0 = if1.centerValid; end
         if (k == 15) f_cend = cs1;
         if (if1.resultStrobe) begin f_ns++; f_sk = k; f_scol = if1.resultColor; end
         if (if2.resultStrobe) f_ns2++;
      end
   endtask

   task automatic check_frame(input string tag, input logic [1:0] exp_c, input int exp_ns,
                              input logic [1:0] exp_scol, input logic [2:0] exp_v0,
                              input logic [2:0] exp_valid);
      check({tag, " colorSelect"}, 32'(f_c0), 32'(exp_c));
      check({tag, " strobe_count"}, f_ns, exp_ns);
      if (exp_ns == 1) begin
         check({tag, " strobe_cycle"}, f_sk, 4);
         check({tag, " resultColor"}, 32'(f_scol), 32'(exp_scol));
      end
      check({tag, " valid_after_fs"}, 32'(f_v0), 32'(exp_v0));
      check({tag, " valid_end"}, 32'(if1.centerValid), 32'(exp_valid));
      check({tag, " slow_strobe_count"}, f_ns2, 0);
   endtask

   initial begin
      rst_n = 1'b0; x = 11'd5; y = 10'd5; en = 3'b111; xc = '0; yc = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst colorSelect", 32'(cs1), 0);
      check("rst centerValid", 32'(if1.centerValid), 0);
      check("rst centerX", if1.centerX, 0);
      check("rst strobe", 32'(if1.resultStrobe), 0);
      check("rst overrun", 32'(ov1), 0);
      check("rst state", 32'(st1), 32'(S_SYNC));
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Rotation over all three colours; first frame produces nothing
      run_frame(10'd0, 10'd0, 3'b111);
      check_frame("F1", 2'd1, 0, 2'd0, 3'b000, 3'b000);
      run_frame(10'd100, 10'd50, 3'b111);
      check_frame("F2", 2'd2, 1, 2'd1, 3'b000, 3'b010);
      check("F2 centerX green", 32'(if1.centerX[19:10]), 100);
      check("F2 centerY green", 32'(if1.centerY[19:10]), 50);
      check("F2 slow overrun", 32'(ov2), 0);
      run_frame(10'd200, 10'd60, 3'b111);
      check_frame("F3", 2'd0, 1, 2'd2, 3'b010, 3'b110);
      check("F3 centerX blue", 32'(if1.centerX[29:20]), 200);
      check("F3 centerY blue", 32'(if1.centerY[29:20]), 60);
      check("F3 slow overrun", 32'(ov2), 1);

      // Mid-frame enable change takes effect only at the next frame start
      run_frame(10'd300, 10'd70, 3'b101);
      check_frame("F4", 2'd1, 1, 2'd0, 3'b100, 3'b101);
      check("F4 colour held mid-frame", 32'(f_cend), 1);
      check("F4 centerX red", 32'(if1.centerX[9:0]), 300);
      run_frame(10'd110, 10'd55, 3'b101);
      check_frame("F5", 2'd0, 1, 2'd1, 3'b001, 3'b011);
      check("F5 centerX green", 32'(if1.centerX[19:10]), 110);
      run_frame(10'd120, 10'd65, 3'b101);
      check_frame("F6", 2'd2, 1, 2'd0, 3'b010, 3'b011);
      // Green disabled since F5: gone stale after the second following frame start
      run_frame(10'd130, 10'd75, 3'b101);
      check_frame("F7", 2'd0, 1, 2'd2, 3'b001, 3'b101);
      check("F7 centerY blue", 32'(if1.centerY[29:20]), 75);

      // Empty mask: colour held, captures continue on it
      en = 3'b000;
      run_frame(10'd140, 10'd80, 3'b000);
      check_frame("F8", 2'd0, 1, 2'd0, 3'b100, 3'b101);
      run_frame(10'd150, 10'd85, 3'b000);
      check_frame("F9", 2'd0, 1, 2'd0, 3'b001, 3'b001);
      run_frame(10'd160, 10'd90, 3'b000);
      check_frame("F10", 2'd0, 1, 2'd0, 3'b001, 3'b001);
      check("F10 centerX red", 32'(if1.centerX[9:0]), 160);
      check("F10 slow overrun", 32'(ov2), 1);
      check("F10 slow valid", 32'(if2.centerValid), 0);
      check("F10 slow state", 32'(st2), 32'(S_DIVWAIT));

      // Reset in the middle of a divider wait
      xc = 10'd170; yc = 10'd95; en = 3'b111;
      f_ns = 0;
      x = 11'd0; y = 10'd0;
      @(posedge clk); #1;
      x = 11'd1;
      @(posedge clk); #1;
      check("F11 state before reset", 32'(st1), 32'(S_DIVWAIT));
      rst_n = 1'b0;
      #1;
      check("F11 rst colorSelect", 32'(cs1), 0);
      check("F11 rst centerValid", 32'(if1.centerValid), 0);
      check("F11 rst centerX", if1.centerX, 0);
      check("F11 rst centerY", if1.centerY, 0);
      check("F11 rst state", 32'(st1), 32'(S_SYNC));
      check("F11 rst slow overrun", 32'(ov2), 0);
      for (int k = 2; k < 16; k++) begin
         x = 11'(k % 4);
         y = 10'(k / 4);
         @(posedge clk); #1;
         if (k == 3) rst_n = 1'b1;
         if (if1.resultStrobe) f_ns++;
      end
      check("F11 no strobe after reset", f_ns, 0);
      run_frame(10'd180, 10'd99, 3'b111);
      check_frame("F12", 2'd1, 0, 2'd0, 3'b000, 3'b000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
